// File: rtl/s_axi4l_regbank.sv
// Four-word AXI4-Lite register bank: CTRL, SCRATCH, free-running COUNT and
// sticky W1C overflow STATUS, with a registered read port and level interrupt.
module s_axi4l_regbank #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] i_waddr,
  input  logic [AXI_DATA_WIDTH-1:0] i_wdata,
  input  logic                      i_wvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] i_raddr,
  input  logic                      i_rvalid,
  output logic [AXI_DATA_WIDTH-1:0] o_rdata,
  output logic                      o_rdata_valid,
  output logic                      o_irq
);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_SCRATCH = 2'd1,
    REG_COUNT   = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int DW = AXI_DATA_WIDTH;

  logic [1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic [DW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          irq_q, irq_d;

  reg_sel_e wsel;
  reg_sel_e rsel;
  logic     cnt_step;

  assign wsel = reg_sel_e'(i_waddr[3:2]);
  assign rsel = reg_sel_e'(i_raddr[3:2]);

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    ctrl_d        = ctrl_q;
    scratch_d     = scratch_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    rdata_d       = rdata_q;
    rdata_valid_d = i_rvalid;
    cnt_step      = 1'b0;

    if (i_wvalid) begin
      case (wsel)
        REG_CTRL:    ctrl_d    = i_wdata[1:0];
        REG_SCRATCH: scratch_d = i_wdata;
        REG_COUNT:   count_d   = i_wdata;
        REG_STATUS:  if (i_wdata[0]) ovf_d = 1'b0;
        default:     ;
      endcase
    end

    // Enable must hold both before and after this edge; a load of COUNT beats the increment.
    cnt_step = ctrl_q[0] && ctrl_d[0] && !(i_wvalid && wsel == REG_COUNT);
    if (cnt_step) begin
      count_d = count_q + 1'b1;
      // Wrap sets OVF after any W1C above, so the set wins.
      if (&count_q) ovf_d = 1'b1;
    end

    irq_d = ovf_d & ctrl_d[1];

    if (i_rvalid) begin
      case (rsel)
        REG_CTRL:    rdata_d = {{(DW-2){1'b0}}, ctrl_q};
        REG_SCRATCH: rdata_d = scratch_q;
        REG_COUNT:   rdata_d = count_q;
        REG_STATUS:  rdata_d = {{(DW-1){1'b0}}, ovf_q};
        default:     rdata_d = '0;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
    if (!i_axi_aresetn) begin
      ctrl_q        <= '0;
      scratch_q     <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      scratch_q     <= scratch_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      irq_q         <= irq_d;
    end
  end

  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_irq         = irq_q;

endmodule
